// File: rtl/cv32e40p_register_file_ecc_scrub.sv
// SECDED-protected flip-flop register file with background scrubber and fault injection.
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   scan_cg_en_i                scan clock-gate enable, not used functionally
//   raddr_{a,b,c}_i / rdata_*_o three combinational read ports returning corrected data
//   ce_o / ue_o                 per-port {c,b,a} correctable / uncorrectable error flags
//   waddr_{a,b}_i, wdata_*_i,
//   we_{a,b}_i                  two write ports, port b wins on an address clash
//   scrub_en_i                  enable the background scrubber
//   clr_i                       clear error counter, sticky flag and captured address
//   inj_we_i, inj_addr_i,
//   inj_mask_i                  XOR a mask into a stored codeword
//   scrub_busy_o                scrubber is checking or fixing a word
//   ce_count_o                  saturating count of scrub-corrected words
//   ue_sticky_o, ue_addr_o      scrubber saw an uncorrectable word / first such address
//
// Codeword layout: bit 0 is overall parity, bits 1..DATA_WIDTH+P form a Hamming code with
// check bits at power-of-two positions and payload bits in the remaining positions.
module cv32e40p_register_file_ecc_scrub #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FPU            = 0,
  parameter int unsigned ZFINX          = 0,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  // Smallest P with 2**P >= DATA_WIDTH + P + 1
  localparam int unsigned P = (DATA_WIDTH + 4  <= 8)    ? 3  :
                              (DATA_WIDTH + 5  <= 16)   ? 4  :
                              (DATA_WIDTH + 6  <= 32)   ? 5  :
                              (DATA_WIDTH + 7  <= 64)   ? 6  :
                              (DATA_WIDTH + 8  <= 128)  ? 7  :
                              (DATA_WIDTH + 9  <= 256)  ? 8  :
                              (DATA_WIDTH + 10 <= 512)  ? 9  :
                              (DATA_WIDTH + 11 <= 1024) ? 10 : 11,
  localparam int unsigned CODE_WIDTH = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_cg_en_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  output logic [2:0]            ce_o,
  output logic [2:0]            ue_o,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  we_a_i,
  input  logic                  we_b_i,
  input  logic                  scrub_en_i,
  input  logic                  clr_i,
  input  logic                  inj_we_i,
  input  logic [ADDR_WIDTH-1:0] inj_addr_i,
  input  logic [CODE_WIDTH-1:0] inj_mask_i,
  output logic                  scrub_busy_o,
  output logic [CNT_WIDTH-1:0]  ce_count_o,
  output logic                  ue_sticky_o,
  output logic [ADDR_WIDTH-1:0] ue_addr_o
);

  localparam int unsigned HamLen   = DATA_WIDTH + P;
  localparam int unsigned NumWords = (FPU != 0 && ZFINX == 0) ? (1 << ADDR_WIDTH)
                                                              : (1 << (ADDR_WIDTH - 1));
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam int unsigned TimerW   = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef logic [CODE_WIDTH-1:0] cw_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ce;
    logic                  ue;
  } dec_t;

  typedef enum logic [1:0] {StIdle, StCheck, StFix} state_e;

  function automatic cw_t ecc_encode(logic [DATA_WIDTH-1:0] data);
    cw_t                   cw;
    logic [DATA_WIDTH-1:0] rem;
    logic [P-1:0]          pos;
    logic [P-1:0]          syn;
    cw  = '0;
    rem = data;
    pos = '0;
    syn = '0;
    for (int unsigned i = 0; i < HamLen; i++) begin
      pos = pos + 1'b1;
      if ((pos & (pos - 1'b1)) != '0) begin
        cw[pos] = rem[0];
        rem     = rem >> 1;
        if (cw[pos]) syn = syn ^ pos;
      end
    end
    // Each check bit cancels its own syndrome bit, so the payload syndrome is the check vector
    pos = '0;
    for (int unsigned i = 0; i < HamLen; i++) begin
      pos = pos + 1'b1;
      if ((pos & (pos - 1'b1)) == '0) cw[pos] = |(syn & pos);
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic dec_t ecc_decode(cw_t cw);
    dec_t                  r;
    cw_t                   fix;
    logic [DATA_WIDTH-1:0] rem;
    logic [P-1:0]          pos;
    logic [P-1:0]          syn;
    logic                  par;
    syn = '0;
    pos = '0;
    for (int unsigned i = 0; i < HamLen; i++) begin
      pos = pos + 1'b1;
      if (cw[pos]) syn = syn ^ pos;
    end
    par = ^cw;
    fix = cw;
    if (syn != '0 && par && (32'(syn) < CODE_WIDTH)) fix[syn] = ~fix[syn];
    // A double error leaves fix == cw, so raw payload bits pass through
    rem = '0;
    pos = '0;
    for (int unsigned i = 0; i < HamLen; i++) begin
      pos = pos + 1'b1;
      if ((pos & (pos - 1'b1)) != '0) rem = {fix[pos], rem[DATA_WIDTH-1:1]};
    end
    r.data = rem;
    r.ce   = par;
    r.ue   = (syn != '0) && !par;
    return r;
  endfunction

  cw_t                   mem_q [NumWords];
  cw_t                   mem_d [NumWords];
  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  ce_cnt_q, ce_cnt_d;
  logic                  sticky_q, sticky_d;
  logic [ADDR_WIDTH-1:0] ue_addr_q, ue_addr_d;

  logic [IdxW-1:0] ra_idx, rb_idx, rc_idx, wa_idx, wb_idx, inj_idx, ptr_inc;
  dec_t            rd_a, rd_b, rd_c, scrub_dec;
  logic            inj_ok, scrub_hit, scrub_wr;
  logic            unused_sigs;

  assign unused_sigs = ^{scan_cg_en_i, raddr_a_i, raddr_b_i, raddr_c_i,
                         waddr_a_i, waddr_b_i, inj_addr_i};

  assign ra_idx  = raddr_a_i[IdxW-1:0];
  assign rb_idx  = raddr_b_i[IdxW-1:0];
  assign rc_idx  = raddr_c_i[IdxW-1:0];
  assign wa_idx  = waddr_a_i[IdxW-1:0];
  assign wb_idx  = waddr_b_i[IdxW-1:0];
  assign inj_idx = inj_addr_i[IdxW-1:0];

  // Index 0 is x0 in both layouts; FP registers live in the upper half only
  assign rd_a = (ra_idx == '0) ? '0 : ecc_decode(mem_q[ra_idx]);
  assign rd_b = (rb_idx == '0) ? '0 : ecc_decode(mem_q[rb_idx]);
  assign rd_c = (rc_idx == '0) ? '0 : ecc_decode(mem_q[rc_idx]);

  assign rdata_a_o = rd_a.data;
  assign rdata_b_o = rd_b.data;
  assign rdata_c_o = rd_c.data;
  assign ce_o      = {rd_c.ce, rd_b.ce, rd_a.ce};
  assign ue_o      = {rd_c.ue, rd_b.ue, rd_a.ue};

  assign scrub_dec = ecc_decode(mem_q[ptr_q]);
  assign ptr_inc   = (ptr_q == IdxW'(NumWords - 1)) ? IdxW'(1) : ptr_q + 1'b1;

  assign inj_ok    = inj_we_i && (inj_idx != '0) &&
                     !(we_a_i && wa_idx == inj_idx) && !(we_b_i && wb_idx == inj_idx);
  assign scrub_hit = (we_a_i && wa_idx == ptr_q) || (we_b_i && wb_idx == ptr_q) ||
                     (inj_we_i && inj_idx == ptr_q);

  always_comb begin
    mem_d = mem_q;
    if (inj_ok) mem_d[inj_idx] = mem_q[inj_idx] ^ inj_mask_i;
    if (scrub_wr) mem_d[ptr_q] = ecc_encode(scrub_dec.data);
    if (we_a_i && wa_idx != '0) mem_d[wa_idx] = ecc_encode(wdata_a_i);
    if (we_b_i && wb_idx != '0) mem_d[wb_idx] = ecc_encode(wdata_b_i);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    ce_cnt_d  = ce_cnt_q;
    sticky_d  = sticky_q;
    ue_addr_d = ue_addr_q;
    scrub_wr  = 1'b0;
    case (state_q)
      StIdle: begin
        if (scrub_en_i) begin
          if (timer_q == '0) begin
            state_d = StCheck;
            timer_d = TimerW'(SCRUB_INTERVAL - 1);
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (!scrub_en_i) begin
          timer_d = TimerW'(SCRUB_INTERVAL - 1);
        end else if (scrub_dec.ue) begin
          sticky_d = 1'b1;
          if (!sticky_q) ue_addr_d = ADDR_WIDTH'(ptr_q);
          ptr_d = ptr_inc;
        end else if (scrub_dec.ce) begin
          state_d = StFix;
        end else begin
          ptr_d = ptr_inc;
        end
      end
      StFix: begin
        if (!scrub_en_i) begin
          state_d = StIdle;
          timer_d = TimerW'(SCRUB_INTERVAL - 1);
        end else if (!scrub_dec.ce && !scrub_dec.ue) begin
          // Someone rewrote the word since CHECK; nothing left to repair
          state_d = StIdle;
          ptr_d   = ptr_inc;
        end else if (!scrub_hit) begin
          scrub_wr = 1'b1;
          if (ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + 1'b1;
          state_d = StIdle;
          ptr_d   = ptr_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clr_i) begin
      ce_cnt_d  = '0;
      sticky_d  = 1'b0;
      ue_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q     <= '{default: '0};  // encode(0) is the all-zero codeword
      state_q   <= StIdle;
      timer_q   <= TimerW'(SCRUB_INTERVAL - 1);
      ptr_q     <= IdxW'(1);
      ce_cnt_q  <= '0;
      sticky_q  <= 1'b0;
      ue_addr_q <= '0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      ce_cnt_q  <= ce_cnt_d;
      sticky_q  <= sticky_d;
      ue_addr_q <= ue_addr_d;
    end
  end

  assign scrub_busy_o = (state_q != StIdle);
  assign ce_count_o   = ce_cnt_q;
  assign ue_sticky_o  = sticky_q;
  assign ue_addr_o    = ue_addr_q;

endmodule

// File: tb/tb_cv32e40p_register_file_ecc_scrub.sv
// Randomized bench with a behavioural model: each word is tracked as payload plus the set of
// flipped codeword bits; the number of flipped bits alone decides clean / correctable / double.
module tb_cv32e40p_register_file_ecc_scrub;

  localparam int SI   = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n, scan_cg_en, we_a, we_b, scrub_en, clr, inj_we;
  logic [5:0]  raddr_a, raddr_b, raddr_c, waddr_a, waddr_b, inj_addr;
  logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b, rdata_c;
  logic [38:0] inj_mask;
  logic [2:0]  ce, ue;
  logic        busy, sticky;
  logic [3:0]  cnt;
  logic [5:0]  uaddr;

  always #5 clk = ~clk;

  cv32e40p_register_file_ecc_scrub #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(0), .ZFINX(0), .SCRUB_INTERVAL(SI), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(scan_cg_en),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c),
    .ce_o(ce), .ue_o(ue),
    .waddr_a_i(waddr_a), .waddr_b_i(waddr_b), .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
    .we_a_i(we_a), .we_b_i(we_b), .scrub_en_i(scrub_en), .clr_i(clr),
    .inj_we_i(inj_we), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask),
    .scrub_busy_o(busy), .ce_count_o(cnt), .ue_sticky_o(sticky), .ue_addr_o(uaddr)
  );

  // Model: 0 = idle, 1 = check, 2 = fix
  logic [31:0] m_data [32];
  logic [38:0] m_mask [32];
  logic [31:0] n_data [32];
  logic [38:0] n_mask [32];
  int m_state, m_timer, m_ptr, m_cnt, m_uaddr, n_state, n_timer, n_ptr, n_cnt, n_uaddr;
  bit m_sticky, n_sticky, chk_on;
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_port(input string name, input logic [5:0] a, input logic [31:0] d,
                                   input logic c, input logic u);
    int pc;
    if (a == 0) begin
      chk({name, "_data"}, d, 0);
      chk({name, "_ce"}, c, 0);
      chk({name, "_ue"}, u, 0);
    end else begin
      pc = $countones(m_mask[a]);
      if (pc < 2) chk({name, "_data"}, d, m_data[a]);
      chk({name, "_ce"}, c, pc == 1);
      chk({name, "_ue"}, u, pc >= 2);
    end
  endfunction

  function automatic void check_outputs();
    chk_port("rd_a", raddr_a, rdata_a, ce[0], ue[0]);
    chk_port("rd_b", raddr_b, rdata_b, ce[1], ue[1]);
    chk_port("rd_c", raddr_c, rdata_c, ce[2], ue[2]);
    chk("busy", busy, m_state != 0);
    chk("ce_count", cnt, m_cnt);
    chk("ue_sticky", sticky, m_sticky);
    chk("ue_addr", uaddr, m_uaddr);
  endfunction

  function automatic int nxt(input int p);
    return (p == 31) ? 1 : p + 1;
  endfunction

  function automatic void compute_next();
    int  pc;
    bit  hit;
    n_data = m_data;   n_mask = m_mask;
    n_state = m_state; n_timer = m_timer; n_ptr = m_ptr;
    n_cnt = m_cnt;     n_sticky = m_sticky; n_uaddr = m_uaddr;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        n_data[i] = 0;
        n_mask[i] = 0;
      end
      n_state = 0; n_timer = SI - 1; n_ptr = 1; n_cnt = 0; n_sticky = 0; n_uaddr = 0;
      return;
    end
    hit = (we_a && int'(waddr_a) == m_ptr) || (we_b && int'(waddr_b) == m_ptr) ||
          (inj_we && int'(inj_addr) == m_ptr);
    pc = $countones(m_mask[m_ptr]);
    if (m_state == 0) begin
      if (scrub_en) begin
        if (m_timer == 0) begin n_state = 1; n_timer = SI - 1; end
        else n_timer = m_timer - 1;
      end
    end else if (!scrub_en) begin
      n_state = 0; n_timer = SI - 1;
    end else if (m_state == 1) begin
      n_state = 0;
      if (pc >= 2) begin
        n_sticky = 1;
        if (!m_sticky) n_uaddr = m_ptr;
        n_ptr = nxt(m_ptr);
      end else if (pc == 1) n_state = 2;
      else n_ptr = nxt(m_ptr);
    end else begin
      if (pc == 0) begin
        n_state = 0; n_ptr = nxt(m_ptr);
      end else if (!hit) begin
        n_mask[m_ptr] = 0;
        if (m_cnt < CMAX) n_cnt = m_cnt + 1;
        n_state = 0; n_ptr = nxt(m_ptr);
      end
    end
    if (inj_we && inj_addr != 0 && !(we_a && waddr_a == inj_addr) &&
        !(we_b && waddr_b == inj_addr))
      n_mask[inj_addr] = m_mask[inj_addr] ^ inj_mask;
    if (we_a && waddr_a != 0) begin n_data[waddr_a] = wdata_a; n_mask[waddr_a] = 0; end
    if (we_b && waddr_b != 0) begin n_data[waddr_b] = wdata_b; n_mask[waddr_b] = 0; end
    if (clr) begin n_cnt = 0; n_sticky = 0; n_uaddr = 0; end
  endfunction

  task automatic tick();
    compute_next();
    @(posedge clk);
    @(negedge clk);
    m_data = n_data;   m_mask = n_mask;
    m_state = n_state; m_timer = n_timer; m_ptr = n_ptr;
    m_cnt = n_cnt;     m_sticky = n_sticky; m_uaddr = n_uaddr;
    if (chk_on) check_outputs();
  endtask

  // kind 0: ptr == p; kind 1: fixing word p; kind 2: fixing any word
  task automatic run_until(input int kind, input int p, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (kind == 0) ? (m_ptr == p) : (kind == 1) ? (m_state == 2 && m_ptr == p)
                                                     : (m_state == 2);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_kind%0d_p%0d: got timeout expected event", kind, p);
    end
  endtask

  task automatic quiet();
    we_a = 0; we_b = 0; inj_we = 0; clr = 0; inj_mask = '0;
  endtask

  task automatic set_raddr(input logic [5:0] a);
    raddr_a = a; raddr_b = a; raddr_c = a;
  endtask

  initial begin
    int tgt;
    logic [38:0] mk;
    rst_n = 0; scan_cg_en = 0; scrub_en = 0; quiet();
    set_raddr(0); waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0; inj_addr = 0;
    chk_on = 0;
    tick();
    chk_on = 1;
    tick();
    rst_n = 1;
    tick();
    chk("rst_count", cnt, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_uaddr", uaddr, 0);
    chk("rst_busy", busy, 0);

    // Plain write then read on all three ports
    we_a = 1; waddr_a = 5; wdata_a = 32'hDEADBEEF; set_raddr(5);
    tick();
    quiet();
    chk("x5_a", rdata_a, 32'hDEADBEEF);
    chk("x5_b", rdata_b, 32'hDEADBEEF);
    chk("x5_c", rdata_c, 32'hDEADBEEF);
    chk("x5_ce", ce, 0);
    chk("x5_ue", ue, 0);

    // Single-bit error is corrected on read, then repaired by the scrubber
    inj_we = 1; inj_addr = 5; inj_mask = 39'h8;
    tick();
    quiet();
    chk("x5_inj_data", rdata_a, 32'hDEADBEEF);
    chk("x5_inj_ce", ce[0], 1);
    scrub_en = 1;
    run_until(0, 6, 200);
    chk("x5_scrub_cnt", cnt, 1);
    chk("x5_scrub_ce", ce[0], 0);

    // Double errors: sticky flag captures the first address only
    scrub_en = 0; tick();
    inj_we = 1; inj_addr = 7; inj_mask = 39'h3; set_raddr(7);
    tick();
    quiet();
    chk("x7_ue", ue[0], 1);
    scrub_en = 1;
    run_until(0, 8, 100);
    chk("x7_sticky", sticky, 1);
    chk("x7_uaddr", uaddr, 7);
    scrub_en = 0; tick();
    inj_we = 1; inj_addr = 9; inj_mask = 39'h5;
    tick();
    quiet();
    scrub_en = 1;
    run_until(0, 10, 100);
    chk("x9_uaddr", uaddr, 7);
    clr = 1; tick(); clr = 0;
    chk("clr_sticky", sticky, 0);
    chk("clr_uaddr", uaddr, 0);

    // Functional write to the word being fixed blocks the scrub write
    scrub_en = 0; tick();
    inj_we = 1; inj_addr = 3; inj_mask = 39'h1000; set_raddr(3);
    tick();
    quiet();
    scrub_en = 1;
    run_until(1, 3, 1000);
    we_a = 1; waddr_a = 3; wdata_a = 32'h12345678;
    tick();
    quiet();
    tick();
    chk("x3_data", rdata_a, 32'h12345678);
    chk("x3_ce", ce[0], 0);
    chk("x3_cnt", cnt, 0);

    // Port b wins; x0 stays zero
    scrub_en = 0;
    we_a = 1; waddr_a = 4; wdata_a = 1; we_b = 1; waddr_b = 4; wdata_b = 2; set_raddr(4);
    tick();
    quiet();
    chk("x4_b_wins", rdata_a, 2);
    we_a = 1; waddr_a = 0; wdata_a = 32'hFFFF; set_raddr(0);
    tick();
    quiet();
    chk("x0_zero", rdata_a, 0);

    // Reset while the scrubber is in FIX
    tgt = m_ptr;
    inj_we = 1; inj_addr = 6'(tgt); inj_mask = 39'h400;
    tick();
    quiet();
    scrub_en = 1;
    run_until(2, 0, 100);
    rst_n = 0; set_raddr(6'(tgt));
    tick();
    rst_n = 1;
    chk("rstfix_busy", busy, 0);
    chk("rstfix_cnt", cnt, 0);
    chk("rstfix_data", rdata_a, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      quiet();
      rst_n    = ($urandom_range(0, 499) != 0);
      scrub_en = ($urandom_range(0, 7) != 0);
      clr      = ($urandom_range(0, 63) == 0);
      raddr_a  = 6'($urandom_range(0, 31));
      raddr_b  = 6'($urandom_range(0, 31));
      raddr_c  = 6'($urandom_range(0, 31));
      we_a     = ($urandom_range(0, 3) == 0);
      we_b     = ($urandom_range(0, 3) == 0);
      waddr_a  = 6'($urandom_range(0, 31));
      waddr_b  = 6'($urandom_range(0, 31));
      wdata_a  = $urandom;
      wdata_b  = $urandom;
      inj_addr = 6'($urandom_range(1, 31));
      mk = '0;
      mk[$urandom_range(0, 38)] = 1'b1;
      if ($urandom_range(0, 2) == 0) mk[$urandom_range(0, 38)] = 1'b1;
      // Keep every stored word within two flipped bits, and leave the word under repair alone
      if ($urandom_range(0, 5) == 0 && $countones(m_mask[inj_addr] ^ mk) <= 2 &&
          !(m_state != 0 && int'(inj_addr) == m_ptr)) begin
        inj_we = 1; inj_mask = mk;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
